spike_event_encoder: RTL and testbench

- Transmit side of the axon routing interface. It turns a parallel vector of neuron fire pulses into a serial stream of (spike, source_id) events, one event per accepted cycle.
- Sits between the neuron array and the axon router. Its spike_out and source_id outputs drive the router's spike_in and source_id inputs.
- Queues simultaneous firings in a pending bitmap and serves them with a round-robin arbiter.
- Supports downstream backpressure and counts spikes dropped because of bitmap collisions.

---
 rtl/spike_event_encoder.sv | 99 +++++++++
 tb/tb_spike_event_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Serialises per-neuron fire pulses into (spike_out, source_id) events for the axon router.
// Simultaneous firings wait in a pending bitmap and are served round-robin, one per accepted cycle.
module spike_event_encoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [(1<<ADDR_WIDTH)-1:0]   spike_vec,
    input  logic                         out_ready,
    output logic                         spike_out,
    output logic [ADDR_WIDTH-1:0]        source_id,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         drop_count
);

    localparam int N = 1 << ADDR_WIDTH;

    logic [N-1:0]          pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                  spike_out_q, spike_out_d;
    logic [ADDR_WIDTH-1:0] source_id_q, source_id_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;

    logic                  slot_free;
    logic                  grant_vld;
    logic [ADDR_WIDTH-1:0] grant_id;
    logic [N-1:0]          grant_mask;
    logic [N-1:0]          drop_bits;
    logic [ADDR_WIDTH:0]   drop_num;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [ADDR_WIDTH:0]  inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // Round-robin search over the registered bitmap, starting at rr_ptr and wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        slot_free = !spike_out_q || out_ready;
        for (int k = 0; k < N; k++) begin
            logic [ADDR_WIDTH-1:0] idx;
            idx = rr_ptr_q + ADDR_WIDTH'(k);
            if (slot_free && !grant_vld && pending_q[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        if (grant_vld) grant_mask[grant_id] = 1'b1;

        drop_bits = spike_vec & pending_q & ~grant_mask;
        drop_num  = '0;
        for (int i = 0; i < N; i++) begin
            drop_num = drop_num + {{ADDR_WIDTH{1'b0}}, drop_bits[i]};
        end

        pending_d   = (pending_q & ~grant_mask) | spike_vec;
        drop_d      = sat_add(drop_q, drop_num);
        rr_ptr_d    = rr_ptr_q;
        spike_out_d = spike_out_q;
        source_id_d = source_id_q;
        if (grant_vld) begin
            spike_out_d = 1'b1;
            source_id_d = grant_id;
            rr_ptr_d    = grant_id + 1'b1;
        end else if (spike_out_q && out_ready) begin
            spike_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            spike_out_q <= 1'b0;
            source_id_q <= '0;
            drop_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            spike_out_q <= spike_out_d;
            source_id_q <= source_id_d;
            drop_q      <= drop_d;
        end
    end

    assign spike_out  = spike_out_q;
    assign source_id  = source_id_q;
    assign drop_count = drop_q;
    assign busy       = (|pending_q) || spike_out_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Bench for spike_event_encoder: directed vector table, hand sequences, and random traffic
// against a set-based reference model of the pending/round-robin/drop rules.
module tb_spike_event_encoder;

    localparam int AW = 4;
    localparam int CW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  spike_vec;
    logic          out_ready;
    logic          spike_out;
    logic [AW-1:0] source_id;
    logic          busy;
    logic [CW-1:0] drop_count;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit m_pend[N];
    int m_rr;
    bit m_out;
    int m_id;
    int m_drops;

    spike_event_encoder #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .spike_vec(spike_vec), .out_ready(out_ready),
        .spike_out(spike_out), .source_id(source_id), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [15:0] vec;
        bit          rdy;
        bit          e_spk;
        logic [3:0]  e_id;
        bit          e_busy;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit rst, logic [15:0] vec, bit rdy, bit spk, logic [3:0] id,
                                bit bsy, logic [7:0] drp);
        vec_t v;
        v.rst = rst; v.vec = vec; v.rdy = rdy;
        v.e_spk = spk; v.e_id = id; v.e_busy = bsy; v.e_drop = drp;
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_step(bit rst, logic [N-1:0] vec, bit rdy);
        int g;
        int drops;
        if (!rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_rr = 0; m_out = 1'b0; m_id = 0; m_drops = 0;
            return;
        end
        g = -1;
        if (!m_out || rdy) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        drops = 0;
        for (int i = 0; i < N; i++)
            if (vec[i] && m_pend[i] && i != g) drops++;
        m_drops = (m_drops + drops > 255) ? 255 : m_drops + drops;
        if (g >= 0) m_pend[g] = 1'b0;
        for (int i = 0; i < N; i++)
            if (vec[i]) m_pend[i] = 1'b1;
        if (g >= 0) begin
            m_out = 1'b1; m_id = g; m_rr = (g + 1) % N;
        end else if (m_out && rdy) begin
            m_out = 1'b0;
        end
    endfunction

    function automatic bit model_busy();
        bit b;
        b = m_out;
        foreach (m_pend[i]) if (m_pend[i]) b = 1'b1;
        return b;
    endfunction

    task automatic cyc(input bit rst, input logic [N-1:0] vec, input bit rdy);
        rst_n = rst; spike_vec = vec; out_ready = rdy;
        model_step(rst, vec, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; spike_vec = '0; out_ready = 1'b1;
        // reset with everything firing, then release
        add(0, 16'hFFFF, 1, 0, 0, 0, 0);
        add(0, 16'hFFFF, 1, 0, 0, 0, 0);
        add(1, 16'h0000, 1, 0, 0, 0, 0);
        // single fire of neuron 5
        add(1, 16'h0020, 1, 0, 0, 1, 0);
        add(1, 16'h0000, 1, 1, 5, 1, 0);
        add(1, 16'h0000, 1, 0, 5, 0, 0);
        // simultaneous fires 0, 8, 15 then rr wrap back to 0
        add(0, 16'h0000, 1, 0, 0, 0, 0);
        add(1, 16'h8101, 1, 0, 0, 1, 0);
        add(1, 16'h0000, 1, 1, 0, 1, 0);
        add(1, 16'h0000, 1, 1, 8, 1, 0);
        add(1, 16'h0000, 1, 1, 15, 1, 0);
        add(1, 16'h0001, 1, 0, 15, 1, 0);
        add(1, 16'h0000, 1, 1, 0, 1, 0);
        add(1, 16'h0000, 1, 0, 0, 0, 0);
        // backpressure: event 1 held for five cycles, then 2 follows
        add(0, 16'h0000, 1, 0, 0, 0, 0);
        add(1, 16'h0006, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(1, 16'h0000, 0, 1, 1, 1, 0);
        add(1, 16'h0000, 1, 1, 2, 1, 0);
        add(1, 16'h0000, 1, 0, 2, 0, 0);
        // drop while slot is held, then re-fire on the grant edge
        add(1, 16'h0010, 0, 0, 2, 1, 0);
        add(1, 16'h0008, 0, 1, 4, 1, 0);
        add(1, 16'h0008, 0, 1, 4, 1, 1);
        add(1, 16'h0008, 1, 1, 3, 1, 1);
        add(1, 16'h0000, 1, 1, 3, 1, 1);
        add(1, 16'h0000, 1, 0, 3, 0, 1);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].rst, vt[i].vec, vt[i].rdy);
            check($sformatf("v%0d spike_out", i), int'(spike_out), int'(vt[i].e_spk));
            check($sformatf("v%0d source_id", i), int'(source_id), int'(vt[i].e_id));
            check($sformatf("v%0d busy", i), int'(busy), int'(vt[i].e_busy));
            check($sformatf("v%0d drop_count", i), int'(drop_count), int'(vt[i].e_drop));
        end

        // saturation then reset in the middle of a held event
        cyc(0, '0, 1);
        for (int i = 0; i < 25; i++) cyc(1, 16'hFFFF, 0);
        check("sat drop_count", int'(drop_count), 255);
        check("sat spike_out", int'(spike_out), 1);
        check("sat busy", int'(busy), 1);
        cyc(0, 16'hFFFF, 1);
        check("midrst spike_out", int'(spike_out), 0);
        check("midrst source_id", int'(source_id), 0);
        check("midrst drop_count", int'(drop_count), 0);
        check("midrst busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, '0, 1);
            check($sformatf("post_rst%0d spike_out", i), int'(spike_out), 0);
            check($sformatf("post_rst%0d busy", i), int'(busy), 0);
        end

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r;
            logic [N-1:0] v;
            r = ($urandom_range(0, 199) != 0);
            v = N'($urandom & $urandom & $urandom);
            cyc(r, v, $urandom_range(0, 3) != 0);
            check($sformatf("rnd%0d spike_out", i), int'(spike_out), int'(m_out));
            check($sformatf("rnd%0d source_id", i), int'(source_id), m_id);
            check($sformatf("rnd%0d busy", i), int'(busy), int'(model_busy()));
            check($sformatf("rnd%0d drop_count", i), int'(drop_count), m_drops);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
